fp_add_sched: RTL and testbench

Two-requester scheduler that shares one combinational `fp_adder` (13-bit format: sign, 4-bit exponent, 8-bit fraction with explicit leading one) between two independent clients. Each client presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one request at a time, and a three-state controller registers the operands, lets the adder settle for one cycle and holds the result in an output register until the consumer takes it. The block sits between the operand-issuing logic and the shared floating-point adder datapath.

---
 rtl/fp_sched_pkg.sv | 29 ++
 rtl/fp_adder.sv | 84 ++++++++
 rtl/fp_add_sched.sv | 95 +++++++++
 tb/tb_fp_add_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared number format, field positions and controller state encoding
// for the fp_add_sched scheduler.
`default_nettype none

package fp_sched_pkg;

  localparam int FP_EXP_W  = 4;
  localparam int FP_FRAC_W = 8;
  localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

  localparam int SIGN_POS = FP_W - 1;
  localparam int EXP_MSB  = FP_W - 2;
  localparam int EXP_LSB  = FP_FRAC_W;
  localparam int FRAC_MSB = FP_FRAC_W - 1;
  localparam int FRAC_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DONE = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_adder.sv
// fp_adder: combinational add of two {sign, exp, frac} numbers with explicit leading
// one; exact alignment, round-to-nearest-even, saturate on overflow, flush on underflow.
`default_nettype none

module fp_adder #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic                    a_sign,
  input  logic [EXP_W-1:0]        a_exp,
  input  logic [FRAC_W-1:0]       a_frac,
  input  logic                    b_sign,
  input  logic [EXP_W-1:0]        b_exp,
  input  logic [FRAC_W-1:0]       b_frac,
  output logic [EXP_W+FRAC_W:0]   sum
);

  // Wide enough to hold a fraction shifted by the largest exponent gap, plus carry.
  localparam int SUM_W = FRAC_W + (1 << EXP_W);
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic [EXP_W-1:0]  emin, da, db;
  logic [SUM_W-1:0]  al_a, al_b, mag, rem, half;
  logic [FRAC_W-1:0] kept;
  logic [FRAC_W:0]   rnd;
  logic              res_sign, up;
  int                lead, sh, e;

  always_comb begin
    emin = (a_exp < b_exp) ? a_exp : b_exp;
    da   = a_exp - emin;
    db   = b_exp - emin;
    al_a = SUM_W'(a_frac) << da;
    al_b = SUM_W'(b_frac) << db;

    if (a_sign == b_sign) begin
      mag      = al_a + al_b;
      res_sign = a_sign;
    end else if (al_a >= al_b) begin
      mag      = al_a - al_b;
      res_sign = a_sign;
    end else begin
      mag      = al_b - al_a;
      res_sign = b_sign;
    end

    lead = 0;
    for (int i = 0; i < SUM_W; i++) begin
      if (mag[i]) lead = i;
    end

    sh   = 0;
    rem  = '0;
    half = '0;
    up   = 1'b0;
    if (lead > FRAC_W - 1) begin
      sh   = lead - (FRAC_W - 1);
      kept = FRAC_W'(mag >> sh);
      rem  = mag & ((SUM_W'(1) << sh) - SUM_W'(1));
      half = SUM_W'(1) << (sh - 1);
      up   = (rem > half) || ((rem == half) && kept[0]);
    end else begin
      kept = FRAC_W'(mag << ((FRAC_W - 1) - lead));
    end

    rnd = {1'b0, kept} + (FRAC_W + 1)'(up);
    e   = int'(emin) + lead - (FRAC_W - 1);
    if (rnd[FRAC_W]) begin
      rnd = rnd >> 1;
      e   = e + 1;
    end

    if ((mag == '0) || (e < 0)) begin
      sum = '0;
    end else if (e > EMAX) begin
      sum = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
    end else begin
      sum = {res_sign, EXP_W'(e), rnd[FRAC_W-1:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin scheduler sharing one fp_adder between two valid/ready
// requesters; IDLE/EXEC/DONE controller with a held result register.
`default_nettype none

module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [FP_W-1:0] res_data,
  output logic            res_id
);

  state_t          state, state_nxt;
  logic            last, id_q;
  logic [FP_W-1:0] op_a, op_b, sum;
  logic            acc0, acc1, accept;

  // A ready never looks at its own valid; on a tie the pointer picks !last.
  assign req0_ready = (state == IDLE) && (!req1_valid || last);
  assign req1_ready = (state == IDLE) && (!req0_valid || !last);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      id_q      <= 1'b0;
      last      <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      if (accept) begin
        op_a <= acc1 ? req1_a : req0_a;
        op_b <= acc1 ? req1_b : req0_b;
        id_q <= acc1;
        last <= acc1;
      end
      if (state == EXEC) begin
        res_data  <= sum;
        res_id    <= id_q;
        res_valid <= 1'b1;
      end else if ((state == DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  fp_adder #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_adder (
    .a_sign (op_a[SIGN_POS]),
    .a_exp  (op_a[EXP_MSB:EXP_LSB]),
    .a_frac (op_a[FRAC_MSB:FRAC_LSB]),
    .b_sign (op_b[SIGN_POS]),
    .b_exp  (op_b[EXP_MSB:EXP_LSB]),
    .b_frac (op_b[FRAC_MSB:FRAC_LSB]),
    .sum    (sum)
  );

endmodule

`default_nettype wire

// File: tb/tb_fp_add_sched.sv
// tb_fp_add_sched: directed and random checks of the two-requester fp adder scheduler.
`default_nettype none

module tb_fp_add_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic        req0_ready, req1_ready, res_valid, res_id;
  logic [12:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, res_data;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [12:0] P_2   = 13'b0_0010_10000000;
  localparam logic [12:0] P_2X2 = 13'b0_0011_10000000;
  localparam logic [12:0] P_10  = 13'b0_1010_10000000;
  localparam logic [12:0] P_10O = 13'b0_1010_10000001;
  localparam logic [12:0] P_10E = 13'b0_1010_10000010;
  localparam logic [12:0] BP_A  = 13'b0_0011_11000000;
  localparam logic [12:0] BP_B  = 13'b0_0001_10000000;
  localparam logic [12:0] BP_S  = 13'b0_0011_11100000;

  always #5 clk = ~clk;

  fp_add_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  // Reference: exact value frac*2^exp as an integer, then round-to-nearest-even.
  function automatic logic [12:0] model_add(input logic [12:0] a, input logic [12:0] b);
    longint va, vb, s, mag, kept, rem, half;
    int     k, sh, e;
    logic   sg;
    va = longint'(a[7:0]) <<< a[11:8];
    vb = longint'(b[7:0]) <<< b[11:8];
    if (a[12]) va = -va;
    if (b[12]) vb = -vb;
    s = va + vb;
    if (s == 0) return 13'd0;
    sg  = (s < 0);
    mag = sg ? -s : s;
    k = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) k = i;
    if (k > 7) begin
      sh   = k - 7;
      kept = mag >> sh;
      rem  = mag & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      if (kept == 256) begin
        kept = 128;
        k    = k + 1;
      end
    end else begin
      kept = mag << (7 - k);
    end
    e = k - 7;
    if (e < 0) return 13'd0;
    if (e > 15) return {sg, 4'hF, 8'hFF};
    return {sg, e[3:0], kept[7:0]};
  endfunction

  function automatic logic [12:0] rand_op();
    logic [12:0] v;
    v    = 13'($urandom);
    v[7] = 1'b1;
    if ($urandom_range(7, 0) == 0) v = '0;
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    vectors++; if (res_data !== 13'd0) begin miscompares++; $display("FAIL reset_res_data: got %h want 0", res_data); end
    vectors++; if (res_id !== 1'b0) begin miscompares++; $display("FAIL reset_res_id: got %b want 0", res_id); end
    reset = 1'b0;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready0: got %b want 1", req0_ready); end
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready1: got %b want 1", req1_ready); end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tie_ready0: got %b want 1", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_tie_ready1: got %b want 0", req1_ready); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_a = P_2; req0_b = P_2; req0_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_exec_valid: got %b want 0", res_valid); end
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL single_exec_ready: got %b want 0", req0_ready); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", res_valid); end
    vectors++; if (res_data !== P_2X2) begin miscompares++; $display("FAIL single_data: got %b want %b", res_data, P_2X2); end
    vectors++; if (res_id !== 1'b0) begin miscompares++; $display("FAIL single_id: got %b want 0", res_id); end
    res_ready = 1'b1;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_release: got %b want 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_guard_tie();
    logic [12:0] bv [2];
    logic [12:0] ev [2];
    bv[0] = P_10;  ev[0] = P_10;
    bv[1] = P_10O; ev[1] = P_10E;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      req1_a = P_2; req1_b = bv[v]; req1_valid = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL tie%0d_valid: got %b want 1", v, res_valid); end
      vectors++; if (res_data !== ev[v]) begin miscompares++; $display("FAIL tie%0d_data: got %b want %b", v, res_data, ev[v]); end
      vectors++; if (res_id !== 1'b1) begin miscompares++; $display("FAIL tie%0d_id: got %b want 1", v, res_id); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int last_c = 0;
    logic exp_id = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req0_a = P_2; req0_b = P_2;  req0_valid = 1'b1;
    req1_a = P_2; req1_b = P_10; req1_valid = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      vectors++; if (req0_ready && req1_ready) begin miscompares++; $display("FAIL rr_both_ready c%0d: got 11 want not both", c); end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        vectors++; if (req1_ready !== 1'(n % 2)) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %0d", n, req1_ready, n % 2); end
        if (n > 0) begin
          vectors++; if (c - last_c != 3) begin miscompares++; $display("FAIL rr_spacing%0d: got %0d want 3", n, c - last_c); end
        end
        exp_id = 1'(n % 2);
        last_c = c;
        n++;
      end
      if (res_valid) begin
        vectors++; if (res_id !== exp_id) begin miscompares++; $display("FAIL rr_res_id c%0d: got %b want %b", c, res_id, exp_id); end
        vectors++; if (res_data !== (exp_id ? P_10 : P_2X2)) begin miscompares++; $display("FAIL rr_res_data c%0d: got %b want %b", c, res_data, exp_id ? P_10 : P_2X2); end
      end
    end
    vectors++; if (n != 4) begin miscompares++; $display("FAIL rr_accept_count: got %0d want 4", n); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req0_a = BP_A; req0_b = BP_B; req0_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_a = P_2; req1_b = P_10; req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d: got %b want 1", c, res_valid); end
      vectors++; if (res_data !== BP_S) begin miscompares++; $display("FAIL bp_data c%0d: got %b want %b", c, res_data, BP_S); end
      vectors++; if (res_id !== 1'b0) begin miscompares++; $display("FAIL bp_id c%0d: got %b want 0", c, res_id); end
      vectors++; if (req0_ready || req1_ready) begin miscompares++; $display("FAIL bp_readies c%0d: got %b%b want 00", c, req0_ready, req1_ready); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", res_valid); end
    vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle_ready1: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_pending_valid: got %b want 1", res_valid); end
    vectors++; if (res_id !== 1'b1) begin miscompares++; $display("FAIL bp_pending_id: got %b want 1", res_id); end
    vectors++; if (res_data !== P_10) begin miscompares++; $display("FAIL bp_pending_data: got %b want %b", res_data, P_10); end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Reset while DONE holds a requester-1 result.
    @(negedge clk);
    req1_a = P_2; req1_b = P_10; req1_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b1 || res_id !== 1'b1) begin miscompares++; $display("FAIL rst_done_pre: got %b/%b want 1/1", res_valid, res_id); end
    reset = 1'b1;
    #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_done_valid: got %b want 0", res_valid); end
    vectors++; if (res_data !== 13'd0) begin miscompares++; $display("FAIL rst_done_data: got %h want 0", res_data); end
    vectors++; if (res_id !== 1'b0) begin miscompares++; $display("FAIL rst_done_id: got %b want 0", res_id); end
    @(negedge clk);
    reset = 1'b0;
    // Reset while EXEC holds a requester-0 operation.
    @(negedge clk);
    req0_a = P_2; req0_b = P_2; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_exec_valid: got %b want 0", res_valid); end
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rst_exec_ready0: got %b want 1", req0_ready); end
    @(negedge clk);
    reset = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_discard c%0d: got %b want 0", c, res_valid); end
    end
    res_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_first_grant: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++; if (res_valid !== 1'b1 || res_id !== 1'b0) begin miscompares++; $display("FAIL rst_post_result: got %b/%b want 1/0", res_valid, res_id); end
    vectors++; if (res_data !== P_2X2) begin miscompares++; $display("FAIL rst_post_data: got %b want %b", res_data, P_2X2); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] sb [$];
    logic [13:0] expv;
    logic        acc0, acc1, hs;
    logic        acc0_p = 1'b0, acc1_p = 1'b0;
    int          accepts = 0, results = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!req0_valid || acc0_p) begin
        if (c < 360 && $urandom_range(1, 0) == 1) begin
          req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1;
        end else req0_valid = 1'b0;
      end
      if (!req1_valid || acc1_p) begin
        if (c < 360 && $urandom_range(1, 0) == 1) begin
          req1_a = rand_op(); req1_b = rand_op(); req1_valid = 1'b1;
        end else req1_valid = 1'b0;
      end
      res_ready = (c >= 360) ? 1'b1 : 1'($urandom_range(1, 0));
      #1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      hs   = res_valid && res_ready;
      if (acc0 && acc1) begin
        vectors++; miscompares++;
        $display("FAIL rand_double_accept c%0d: got 2 accepts want at most 1", c);
      end
      if (acc0) begin sb.push_back({1'b0, model_add(req0_a, req0_b)}); accepts++; end
      if (acc1) begin sb.push_back({1'b1, model_add(req1_a, req1_b)}); accepts++; end
      if (hs) begin
        results++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra_result c%0d: got %b/%b want none", c, res_id, res_data);
        end else begin
          expv = sb.pop_front();
          if ({res_id, res_data} !== expv) begin
            miscompares++;
            $display("FAIL rand_result c%0d: got id %b data %b want id %b data %b", c, res_id, res_data, expv[13], expv[12:0]);
          end
        end
      end
      acc0_p = acc0;
      acc1_p = acc1;
    end
    vectors++; if (sb.size() != 0 || accepts != results || accepts == 0) begin miscompares++; $display("FAIL rand_drain: got %0d accepts %0d results want equal and nonzero", accepts, results); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_guard_tie();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
